serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 119 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder: adds WIDTH-bit operands DIGIT bits per cycle, LSB digit first.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [DIGIT:0]   digit_sum;
   logic [31:0]      base;
   logic             last;

   // Handshake: start is sampled only while busy=0; done is a one-cycle pulse per result.
   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign last = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The operands stay put; the counter selects the digit, so N=1 needs no special case.
   always_comb begin
      base      = 32'(cnt) * 32'(DIGIT);
      digit_sum = {1'b0, a_q[base +: DIGIT]} + {1'b0, b_q[base +: DIGIT]}
                + {{DIGIT{1'b0}}, carry};
      acc_next  = acc;
      acc_next[base +: DIGIT] = digit_sum[DIGIT-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  carry <= cin;
                  cnt   <= '0;
                  acc   <= '0;
               end
            end
            RUN: begin
               acc   <= acc_next;
               carry <= digit_sum[DIGIT];
               cnt   <= cnt + CW'(1);
               if (last) begin
                  sum  <= acc_next;
                  cout <= digit_sum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                  ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (acc_next[WIDTH-1] != a_q[WIDTH-1]);
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
